// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: sequencing controller for a cascaded synchronous counter
// chain with a multiplexed 7-segment display.
//   - A six-state FSM issues the one-cycle active-low clear/load strobes and
//     the count enables for the chain.
//   - A tick prescaler turns clk_50mhz into one enp pulse per count step.
//   - An independent scan prescaler rotates the active-low digit select.
// All outputs are registered. Reset is synchronous and active-high.
module count_seq_ctrl #(
  parameter int TICK_DIV = 50000000,  // clk_50mhz cycles per count tick
  parameter int SCAN_DIV = 50000      // clk_50mhz cycles per digit step
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       load_req,
  input  logic       clear_req,
  input  logic       stop_at_tc,
  input  logic       rco_all,
  output logic       clrn,
  output logic       ldn,
  output logic       enp,
  output logic       ent,
  output logic [2:0] sel,
  output logic [2:0] state_o,
  output logic       done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] scan_cnt_q;
  logic [2:0]    sel_q;
  logic          clrn_q, ldn_q, enp_q, ent_q, done_q;
  logic          tick;
  logic          accepts_req;
  logic          enp_d;

  assign tick = (tick_cnt_q == TICK_MAX);

  // CLEAR/LOAD always fall back to IDLE for one cycle, so a held request can
  // never stretch a strobe; unused encodings also bypass request handling.
  assign accepts_req = (state_q == S_IDLE) || (state_q == S_RUN) ||
                       (state_q == S_PAUSE) || (state_q == S_DONE);

  // Next-state, prescaler next value and tick enable.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = S_IDLE;
    tick_cnt_d = tick_cnt_q;

    case (state_q)
      S_IDLE:  state_d = (start && !stop) ? S_RUN : S_IDLE;
      S_PAUSE: state_d = (start && !stop) ? S_RUN : S_PAUSE;
      S_RUN: begin
        if (stop)                               state_d = S_PAUSE;
        else if (tick && stop_at_tc && rco_all) state_d = S_DONE;
        else                                    state_d = S_RUN;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (accepts_req) begin
      if (clear_req)     state_d = S_CLEAR;
      else if (load_req) state_d = S_LOAD;
    end

    // Restart the prescaler on every RUN entry; count only while in RUN.
    if (state_d == S_RUN && state_q != S_RUN) tick_cnt_d = '0;
    else if (state_q == S_RUN)                tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    // A tick only advances the chain when RUN continues; stop, terminal-count
    // halt and any request all suppress it.
    enp_d = (state_q == S_RUN) && (state_d == S_RUN) && tick;
  end

  // FSM state, tick prescaler and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      clrn_q     <= 1'b1;
      ldn_q      <= 1'b1;
      enp_q      <= 1'b0;
      ent_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      clrn_q     <= (state_d != S_CLEAR);
      ldn_q      <= (state_d != S_LOAD);
      enp_q      <= enp_d;
      ent_q      <= (state_d == S_RUN);
      done_q     <= (state_d == S_DONE);
    end
  end

  // Display scan: free-running prescaler rotating the low digit select bit.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      scan_cnt_q <= '0;
      sel_q      <= 3'b110;
    end else if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_q <= '0;
      case (sel_q)
        3'b110:  sel_q <= 3'b101;
        3'b101:  sel_q <= 3'b011;
        default: sel_q <= 3'b110;  // also recovers any corrupted pattern
      endcase
    end else begin
      scan_cnt_q <= scan_cnt_q + SW'(1);
    end
  end

  assign clrn    = clrn_q;
  assign ldn     = ldn_q;
  assign enp     = enp_q;
  assign ent     = ent_q;
  assign done    = done_q;
  assign sel     = sel_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with TICK_DIV=4, SCAN_DIV=3.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_count_seq_ctrl;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic       clk = 1'b0;
  logic       rst, start, stop, load_req, clear_req, stop_at_tc, rco_all;
  logic       clrn, ldn, enp, ent, done;
  logic [2:0] sel, state_o;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference scan model: cycle within digit, digit index.
  int         sc_m = 0;
  int         si_m = 0;
  logic [2:0] sel_pat [3] = '{3'b110, 3'b101, 3'b011};

  count_seq_ctrl #(.TICK_DIV(4), .SCAN_DIV(3)) dut (
    .clk_50mhz (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .load_req  (load_req),
    .clear_req (clear_req),
    .stop_at_tc(stop_at_tc),
    .rco_all   (rco_all),
    .clrn      (clrn),
    .ldn       (ldn),
    .enp       (enp),
    .ent       (ent),
    .sel       (sel),
    .state_o   (state_o),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pk(input logic [2:0] st, input logic c, input logic l,
                                    input logic e, input logic t, input logic d);
    return {st, c, l, e, t, d};
  endfunction

  task automatic check_outs(input string tag, input logic [7:0] exp);
    check(tag, {state_o, clrn, ldn, enp, ent, done}, exp);
  endtask

  // One clock: advance the scan model with the reset seen at the edge,
  // then check the digit select.
  task automatic tick_clk();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    if (r) begin
      sc_m = 0;
      si_m = 0;
    end else if (sc_m == 2) begin
      sc_m = 0;
      si_m = (si_m + 1) % 3;
    end else begin
      sc_m++;
    end
    check("sel", {5'd0, sel}, {5'd0, sel_pat[si_m]});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; load_req = 1'b0;
    clear_req = 1'b0; stop_at_tc = 1'b0; rco_all = 1'b0;
    tick_clk();
    tick_clk();
    check_outs("reset", pk(ST_IDLE, 1, 1, 0, 0, 0));
    rst = 1'b0;

    tick_clk();
    check_outs("idle_hold", pk(ST_IDLE, 1, 1, 0, 0, 0));

    // stop outranks start in IDLE
    stop = 1'b1; start = 1'b1;
    tick_clk();
    check_outs("idle_stop_over_start", pk(ST_IDLE, 1, 1, 0, 0, 0));
    stop = 1'b0;

    // RUN entry, enp at cycles 4, 8, 12 after entry; run on to prescaler=2
    tick_clk();
    check_outs("run_entry", pk(ST_RUN, 1, 1, 0, 1, 0));
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick_clk();
      check_outs($sformatf("run_tick_k%0d", k), pk(ST_RUN, 1, 1, (k % 4 == 0), 1, 0));
    end

    // stop at prescaler=2 -> PAUSE, hold, restart
    stop = 1'b1;
    tick_clk();
    check_outs("pause_entry", pk(ST_PAUSE, 1, 1, 0, 0, 0));
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      check_outs("pause_hold", pk(ST_PAUSE, 1, 1, 0, 0, 0));
    end
    start = 1'b1;
    tick_clk();
    check_outs("rerun_entry", pk(ST_RUN, 1, 1, 0, 1, 0));
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick_clk();
      check_outs($sformatf("rerun_k%0d", k), pk(ST_RUN, 1, 1, (k == 4), 1, 0));
    end

    // stop on the tick cycle: stop wins, no enp
    stop = 1'b1;
    tick_clk();
    check_outs("stop_over_tick", pk(ST_PAUSE, 1, 1, 0, 0, 0));
    stop = 1'b0;

    // clear and load together from RUN -> CLEAR only, then IDLE
    start = 1'b1;
    tick_clk();
    check_outs("run_again", pk(ST_RUN, 1, 1, 0, 1, 0));
    start = 1'b0;
    clear_req = 1'b1; load_req = 1'b1;
    tick_clk();
    check_outs("clear_over_load", pk(ST_CLEAR, 0, 1, 0, 0, 0));
    clear_req = 1'b0; load_req = 1'b0;
    tick_clk();
    check_outs("clear_to_idle", pk(ST_IDLE, 1, 1, 0, 0, 0));

    // held load_req alternates LOAD/IDLE
    load_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      if (i % 2 == 0) check_outs("held_load_strobe", pk(ST_LOAD, 1, 0, 0, 0, 0));
      else            check_outs("held_load_gap", pk(ST_IDLE, 1, 1, 0, 0, 0));
    end
    load_req = 1'b0;
    tick_clk();
    check_outs("load_release", pk(ST_IDLE, 1, 1, 0, 0, 0));

    // halt at terminal count
    stop_at_tc = 1'b1; rco_all = 1'b1; start = 1'b1;
    tick_clk();
    check_outs("tc_run_entry", pk(ST_RUN, 1, 1, 0, 1, 0));
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick_clk();
      check_outs("tc_run", pk(ST_RUN, 1, 1, 0, 1, 0));
    end
    tick_clk();
    check_outs("tc_done", pk(ST_DONE, 1, 1, 0, 0, 1));
    start = 1'b1;
    tick_clk();
    check_outs("done_ignores_start", pk(ST_DONE, 1, 1, 0, 0, 1));
    start = 1'b0; load_req = 1'b1;
    tick_clk();
    check_outs("done_load", pk(ST_LOAD, 1, 0, 0, 0, 0));
    load_req = 1'b0;
    tick_clk();
    check_outs("done_load_idle", pk(ST_IDLE, 1, 1, 0, 0, 0));

    // wrap mode: enp issued at terminal count
    stop_at_tc = 1'b0; start = 1'b1;
    tick_clk();
    check_outs("wrap_run_entry", pk(ST_RUN, 1, 1, 0, 1, 0));
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick_clk();
      check_outs($sformatf("wrap_k%0d", k), pk(ST_RUN, 1, 1, (k == 4), 1, 0));
    end

    // reset on a tick cycle in RUN
    rst = 1'b1;
    tick_clk();
    check_outs("reset_on_tick", pk(ST_IDLE, 1, 1, 0, 0, 0));
    rst = 1'b0; rco_all = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      check_outs("post_reset_idle", pk(ST_IDLE, 1, 1, 0, 0, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, meaning clk_50mhz cycles per count tick (1 Hz), legal range 2..2^26.
REQ-002 Parameter SCAN_DIV, default 50000, meaning clk_50mhz cycles per display-digit step (1 kHz), legal range 2..2^20.
REQ-003 clk_50mhz  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  level, request RUN.
REQ-006 stop  in  1  level, request PAUSE.
REQ-007 load_req  in  1  level, request parallel load of external counter chain.
REQ-008 clear_req  in  1  level, request clear of external counter chain.
REQ-009 stop_at_tc  in  1  mode, 1 = halt in DONE when chain reaches terminal count.
REQ-010 rco_all  in  1  AND of all cascaded counter ripple-carry outputs (chain at terminal count).
REQ-011 clrn  out  1  active-low synchronous clear strobe to counter chain.
REQ-012 ldn  out  1  active-low synchronous load strobe to counter chain.
REQ-013 enp  out  1  count-enable-P, one-cycle pulse per tick.
REQ-014 ent  out  1  count-enable-T, level, high while RUN.
REQ-015 sel  out  3  active-low one-hot digit select for multiplexed 7-segment display.
REQ-016 state_o  out  3  current FSM state encoding.
REQ-017 done  out  1  high while in DONE.

Function
REQ-018 FSM states and encodings: IDLE=0, CLEAR=1, LOAD=2, RUN=3, PAUSE=4, DONE=5; unused encodings SHALL go to IDLE next cycle.
REQ-019 Request priority, evaluated every cycle in every state: clear_req > load_req > stop > start.
REQ-020 Any state with clear_req=1 -> CLEAR; CLEAR lasts exactly one cycle with clrn=0, then -> IDLE.
REQ-021 Any state with clear_req=0, load_req=1 -> LOAD; LOAD lasts exactly one cycle with ldn=0, then -> IDLE.
REQ-022 IDLE/PAUSE with start=1 and no higher request -> RUN; RUN with stop=1 and no higher request -> PAUSE.
REQ-023 Held clear_req or load_req re-enters CLEAR/LOAD every other cycle (CLEAR/LOAD, IDLE, CLEAR/LOAD...); strobes never exceed one cycle low.
REQ-024 Tick prescaler: counter 0..TICK_DIV-1, reset to 0 on every entry to RUN, counts only in RUN, holds value in PAUSE.
REQ-025 Tick: enp=1 for exactly one cycle when prescaler = TICK_DIV-1 in RUN; first enp after RUN entry occurs TICK_DIV cycles after entry; enp=0 in all other states.
REQ-026 ent=1 only in RUN.
REQ-027 RUN with stop_at_tc=1, rco_all=1 and tick cycle: enp SHALL be suppressed that cycle and FSM -> DONE (chain not advanced past terminal count).
REQ-028 RUN with stop_at_tc=0: chain wraps; enp issued normally at rco_all=1.
REQ-029 DONE: holds until clear_req or load_req; start ignored; done=1.
REQ-030 Simultaneous stop and tick in RUN: stop wins, enp=0 that cycle.
REQ-031 clrn and ldn never low in same cycle.
REQ-032 Scan: independent prescaler 0..SCAN_DIV-1, runs in all states; on wrap sel rotates 110->101->011->110.
REQ-033 Exactly one sel bit low at all times after reset.

Reset
REQ-034 rst=1 at a clock edge: state IDLE, both prescalers 0, clrn=1, ldn=1, enp=0, ent=0, done=0, sel=110, state_o=0.
REQ-035 rst has priority over all requests; rst mid-RUN aborts with no enp pulse in the reset cycle.

Verification
REQ-036 TICK_DIV=4: rst, start pulse -> RUN; enp high at cycles 4, 8, 12 after RUN entry, ent=1 throughout.
REQ-037 RUN, stop at prescaler=2, start 5 cycles later -> PAUSE; after restart first enp exactly 4 cycles after RUN re-entry.
REQ-038 clear_req and load_req both high one cycle from RUN -> CLEAR, clrn=0 one cycle, ldn=1, then IDLE.
REQ-039 stop_at_tc=1, rco_all=1 at tick -> enp=0, DONE, done=1; start ignored; load_req -> ldn=0 one cycle, IDLE.
REQ-040 SCAN_DIV=3 -> sel 110 for 3 cycles, 101 for 3, 011 for 3, repeat; unaffected by FSM activity.
REQ-041 rst asserted in RUN on tick cycle -> enp=0, all outputs at REQ-034 values next cycle.
